// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, the next-pc
// codes produced by the control unit, and the pc register's command encoding.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FU_IDLE  = 2'd0,
    FU_FETCH = 2'd1,
    FU_EXEC  = 2'd2,
    FU_HALT  = 2'd3
  } fu_state_e;

  // Codes 3..7 are reserved and decode as PC_NEXT.
  localparam logic [2:0] PC_NEXT = 3'd0;
  localparam logic [2:0] PC_JUMP = 3'd1;
  localparam logic [2:0] PC_HALT = 3'd2;

  typedef enum logic [1:0] {
    PCOP_HOLD    = 2'd0,
    PCOP_INC     = 2'd1,
    PCOP_LOAD    = 2'd2,
    PCOP_RESTART = 2'd3
  } pc_op_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port plus the instruction/decision exchange with the control unit.
// master = fetch unit side, slave = memory / control unit side.
interface fetch_unit_if #(
  parameter int AW = 5,
  parameter int DW = 8
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [DW-1:0] op;
  logic          op_valid;
  logic [2:0]    pc_sel;

  modport master (
    output mem_req, mem_addr, op, op_valid,
    input  mem_rdata, mem_rvalid, pc_sel
  );

  modport slave (
    input  mem_req, mem_addr, op, op_valid,
    output mem_rdata, mem_rvalid, pc_sel
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter register: hold, increment with natural 2^AW wrap, load a
// jump target, or restart at RESET_PC.
module fetch_pc
  import fetch_unit_pkg::*;
#(
  parameter int AW       = 5,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  pc_op_e        i_op,
  input  logic [AW-1:0] i_load_val,
  output logic [AW-1:0] o_pc
);

  localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC);

  logic [AW-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_INIT;
    end else begin
      unique case (i_op)
        PCOP_INC:     r_pc <= r_pc + AW'(1);
        PCOP_LOAD:    r_pc <= i_load_val;
        PCOP_RESTART: r_pc <= PC_INIT;
        default:      r_pc <= r_pc;
      endcase
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/FETCH/EXEC/HALT sequencing, instruction register
// and req/valid memory handshake; pc storage lives in fetch_pc.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  fetch_unit_if.master  bus,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          busy
);

  fu_state_e     r_state;
  fu_state_e     w_state_nxt;
  logic          r_mem_req;
  logic          w_mem_req_nxt;
  logic [DW-1:0] r_op;
  logic          w_op_load;
  pc_op_e        w_pc_op;
  logic [AW-1:0] w_pc;

  fetch_pc #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_op       (w_pc_op),
    .i_load_val (r_op[AW-1:0]),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FU_IDLE;
      r_mem_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_req <= w_mem_req_nxt;
    end
  end

  // op is written only on an accepted read; it stays put through EXEC and HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
    end else if (w_op_load) begin
      r_op <= bus.mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_req_nxt = r_mem_req;
    w_op_load     = 1'b0;
    w_pc_op       = PCOP_HOLD;
    unique case (r_state)
      FU_IDLE, FU_HALT: begin
        if (start) begin
          w_state_nxt   = FU_FETCH;
          w_mem_req_nxt = 1'b1;
          w_pc_op       = PCOP_RESTART;
        end
      end
      FU_FETCH: begin
        if (bus.mem_rvalid && r_mem_req) begin
          w_op_load     = 1'b1;
          w_state_nxt   = FU_EXEC;
          w_mem_req_nxt = 1'b0;
        end
      end
      FU_EXEC: begin
        // mem_req is raised here so the next fetch address is registered with pc.
        unique case (bus.pc_sel)
          PC_JUMP: begin
            w_pc_op       = PCOP_LOAD;
            w_state_nxt   = FU_FETCH;
            w_mem_req_nxt = 1'b1;
          end
          PC_HALT: begin
            w_state_nxt   = FU_HALT;
          end
          default: begin
            w_pc_op       = PCOP_INC;
            w_state_nxt   = FU_FETCH;
            w_mem_req_nxt = 1'b1;
          end
        endcase
      end
      default: begin
        w_state_nxt   = FU_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = w_pc;
  assign bus.op       = r_op;
  assign bus.op_valid = (r_state == FU_EXEC);
  assign pc           = w_pc;
  assign halted       = (r_state == FU_HALT);
  assign busy         = (r_state == FU_FETCH) || (r_state == FU_EXEC);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, linear fetch, wait states, jump/wrap,
// halt/restart and robustness cases against a small instruction ROM.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rvalid;
  logic [2:0] sel;
  logic [4:0] pc;
  logic       halted;
  logic       busy;
  logic [7:0] rom [32];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.AW(5), .DW(8)) bus ();

  assign bus.mem_rdata  = rom[bus.mem_addr];
  assign bus.mem_rvalid = rvalid;
  assign bus.pc_sel     = sel;

  fetch_unit #(.AW(5), .DW(8), .RESET_PC(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .halted (halted),
    .busy   (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    rvalid = 1'b0;
    sel    = PC_NEXT;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rom[i] = 8'h40 + 8'(i);
    do_reset();
    repeat (5) tick();
    n_total++;
    if (bus.mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.mem_req); else n_pass++;
    n_total++;
    if (pc !== 5'd0) $display("FAIL rst_pc: got %0d want 0", pc); else n_pass++;
    n_total++;
    if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
    n_total++;
    if (bus.op_valid !== 1'b0) $display("FAIL rst_op_valid: got %b want 0", bus.op_valid); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++;
    if (bus.op !== 8'h00) $display("FAIL rst_op: got %h want 00", bus.op); else n_pass++;
  endtask

  task automatic test_linear();
    for (int i = 0; i < 32; i++) rom[i] = 8'h40 + 8'(i);
    do_reset();
    rvalid = 1'b1;
    sel    = PC_NEXT;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 5'(k))
        $display("FAIL lin_fetch%0d: req=%b addr=%0d want req=1 addr=%0d", k, bus.mem_req, bus.mem_addr, k);
      else n_pass++;
      n_total++;
      if (bus.op_valid !== 1'b0) $display("FAIL lin_novalid%0d: got %b want 0", k, bus.op_valid); else n_pass++;
      tick();
      n_total++;
      if (bus.op_valid !== 1'b1 || bus.op !== rom[k] || pc !== 5'(k))
        $display("FAIL lin_exec%0d: valid=%b op=%h pc=%0d want valid=1 op=%h pc=%0d",
                 k, bus.op_valid, bus.op, pc, rom[k], k);
      else n_pass++;
      n_total++;
      if (bus.mem_req !== 1'b0) $display("FAIL lin_req_exec%0d: got %b want 0", k, bus.mem_req); else n_pass++;
      tick();
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 32; i++) rom[i] = 8'hC0 + 8'(i);
    do_reset();
    rvalid = 1'b0;
    sel    = PC_NEXT;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 5'd0 || bus.op_valid !== 1'b0)
        $display("FAIL wait_hold%0d: req=%b addr=%0d valid=%b want 1/0/0", i, bus.mem_req, bus.mem_addr, bus.op_valid);
      else n_pass++;
      tick();
    end
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    n_total++;
    if (bus.op_valid !== 1'b1 || bus.op !== 8'hC0)
      $display("FAIL wait_exec: valid=%b op=%h want 1 c0", bus.op_valid, bus.op);
    else n_pass++;
    tick();
    n_total++;
    if (bus.op_valid !== 1'b0 || bus.mem_addr !== 5'd1 || pc !== 5'd1 || bus.mem_req !== 1'b1)
      $display("FAIL wait_advance: valid=%b addr=%0d pc=%0d req=%b want 0/1/1/1",
               bus.op_valid, bus.mem_addr, pc, bus.mem_req);
    else n_pass++;
  endtask

  task automatic test_jump_wrap();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0]  = 8'b001_10101;
    rom[21] = 8'b001_11111;
    rom[31] = 8'h5A;
    do_reset();
    rvalid = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++;
    if (bus.op !== 8'h35 || bus.op_valid !== 1'b1)
      $display("FAIL jmp_op: op=%h valid=%b want 35 1", bus.op, bus.op_valid);
    else n_pass++;
    sel = PC_JUMP;
    tick();
    n_total++;
    if (bus.mem_addr !== 5'd21) $display("FAIL jmp_addr: got %0d want 21", bus.mem_addr); else n_pass++;
    tick();
    tick();
    n_total++;
    if (bus.mem_addr !== 5'd31) $display("FAIL jmp_addr31: got %0d want 31", bus.mem_addr); else n_pass++;
    sel = PC_NEXT;
    tick();
    n_total++;
    if (pc !== 5'd31 || bus.op !== 8'h5A) $display("FAIL wrap_exec: pc=%0d op=%h want 31 5a", pc, bus.op); else n_pass++;
    tick();
    n_total++;
    if (bus.mem_addr !== 5'd0 || bus.mem_req !== 1'b1)
      $display("FAIL wrap_addr: addr=%0d req=%b want 0 1", bus.mem_addr, bus.mem_req);
    else n_pass++;
  endtask

  task automatic test_halt_restart();
    int bad;
    for (int i = 0; i < 32; i++) rom[i] = 8'h80 + 8'(i);
    do_reset();
    rvalid = 1'b1;
    sel    = PC_NEXT;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) begin
      tick();
      tick();
    end
    tick();
    n_total++;
    if (pc !== 5'd6 || bus.op_valid !== 1'b1) $display("FAIL halt_at6: pc=%0d valid=%b want 6 1", pc, bus.op_valid); else n_pass++;
    sel = PC_HALT;
    tick();
    sel = PC_NEXT;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (halted !== 1'b1 || bus.mem_req !== 1'b0 || pc !== 5'd6 || busy !== 1'b0 || bus.op !== 8'h86) begin
        $display("FAIL halt_hold%0d: halted=%b req=%b pc=%0d busy=%b op=%h want 1/0/6/0/86",
                 i, halted, bus.mem_req, pc, busy, bus.op);
        bad++;
      end else n_pass++;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (bus.mem_addr !== 5'd0 || halted !== 1'b0 || bus.mem_req !== 1'b1)
      $display("FAIL restart: addr=%0d halted=%b req=%b want 0 0 1", bus.mem_addr, halted, bus.mem_req);
    else n_pass++;
  endtask

  task automatic test_robustness();
    for (int i = 0; i < 32; i++) rom[i] = 8'h20 + 8'(i);
    // Asynchronous reset while a fetch is outstanding.
    do_reset();
    rvalid = 1'b1;
    sel    = PC_NEXT;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rvalid = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.mem_req !== 1'b0 || pc !== 5'd0 || bus.op !== 8'h00 || busy !== 1'b0 ||
        halted !== 1'b0 || bus.op_valid !== 1'b0)
      $display("FAIL rst_mid_fetch: req=%b pc=%0d op=%h busy=%b halted=%b valid=%b want all 0",
               bus.mem_req, pc, bus.op, busy, halted, bus.op_valid);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();

    // start during EXEC must not restart at RESET_PC.
    rvalid = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (bus.mem_addr !== 5'd1 || busy !== 1'b1)
      $display("FAIL start_in_exec: addr=%0d busy=%b want 1 1", bus.mem_addr, busy);
    else n_pass++;

    // Reserved pc_sel code advances like NEXT.
    tick();
    sel = 3'd5;
    tick();
    sel = PC_NEXT;
    n_total++;
    if (bus.mem_addr !== 5'd2 || halted !== 1'b0)
      $display("FAIL sel_reserved: addr=%0d halted=%b want 2 0", bus.mem_addr, halted);
    else n_pass++;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    rvalid = 1'b0;
    sel    = PC_NEXT;
    test_reset();
    test_linear();
    test_wait_states();
    test_jump_wrap();
    test_halt_restart();
    test_robustness();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
